alu_mdu: RTL

Parametrised integer execute unit: the RV32IM/RV64IM-capable ALU, generalised in width (XLEN). It also adds signed compares, arithmetic shift, and an iterative multiply/divide path (M extension). It sits in the execute stage between the operand-select muxes and writeback. Operands arrive on a valid/ready request channel and results leave on a valid/ready response channel. Single-cycle ops complete in 1 cycle; MUL/DIV ops occupy the unit for XLEN+2 cycles.

---
 rtl/alu_mdu.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | alu_mdu : XLEN-wide integer execute unit. Single-cycle ALU ops plus an     |
// |           iterative radix-2 multiply / restoring divide path.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [4:0] c_OP_ADD    = 5'd0;
    localparam logic [4:0] c_OP_SUB    = 5'd1;
    localparam logic [4:0] c_OP_AND    = 5'd2;
    localparam logic [4:0] c_OP_OR     = 5'd3;
    localparam logic [4:0] c_OP_XOR    = 5'd4;
    localparam logic [4:0] c_OP_SLT    = 5'd5;
    localparam logic [4:0] c_OP_SLL    = 5'd6;
    localparam logic [4:0] c_OP_SRL    = 5'd7;
    localparam logic [4:0] c_OP_SRA    = 5'd8;
    localparam logic [4:0] c_OP_SLTU   = 5'd9;
    localparam logic [4:0] c_OP_MUL    = 5'd10;
    localparam logic [4:0] c_OP_MULH   = 5'd11;
    localparam logic [4:0] c_OP_MULHSU = 5'd12;
    localparam logic [4:0] c_OP_DIV    = 5'd14;
    localparam logic [4:0] c_OP_DIVU   = 5'd15;
    localparam logic [4:0] c_OP_REM    = 5'd16;
    localparam logic [4:0] c_OP_REMU   = 5'd17;

    localparam logic [XLEN-1:0] c_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [SHW-1:0]    cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opd_q;
    logic              is_div_q;
    logic              hi_q;
    logic              rem_q;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;

    logic              w_accept;
    logic              w_is_md;
    logic              w_is_div;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_iter;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_alu;
    logic [XLEN-1:0]   w_acc_hi;
    logic [XLEN-1:0]   w_acc_lo;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) | (state_q == S_FIX);
    assign result    = result_q;
    assign zero      = zero_q;

    // Operand decode: which ops take signed magnitudes, and the divide corner cases
    assign w_is_md    = (op >= c_OP_MUL) && (op <= c_OP_REMU);
    assign w_is_div   = (op >= c_OP_DIV) && (op <= c_OP_REMU);
    assign w_sgn_a    = (op == c_OP_MUL) || (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                        (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_sgn_b    = (op == c_OP_MUL) || (op == c_OP_MULH) ||
                        (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_a_neg    = w_sgn_a & a[XLEN-1];
    assign w_b_neg    = w_sgn_b & b[XLEN-1];
    assign w_abs_a    = w_a_neg ? (~a + 1'b1) : a;
    assign w_abs_b    = w_b_neg ? (~b + 1'b1) : b;
    assign w_div_zero = w_is_div && (b == '0);
    assign w_div_ovf  = ((op == c_OP_DIV) || (op == c_OP_REM)) &&
                        (a == c_MOST_NEG) && (b == '1);
    assign w_iter     = w_is_md & ~w_div_zero & ~w_div_ovf;
    assign w_shamt    = b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (op)
            c_OP_ADD:  w_alu = a + b;
            c_OP_SUB:  w_alu = a - b;
            c_OP_AND:  w_alu = a & b;
            c_OP_OR:   w_alu = a | b;
            c_OP_XOR:  w_alu = a ^ b;
            c_OP_SLT:  w_alu[0] = ($signed(a) < $signed(b));
            c_OP_SLL:  w_alu = a << w_shamt;
            c_OP_SRL:  w_alu = a >> w_shamt;
            c_OP_SRA:  w_alu = $signed(a) >>> w_shamt;
            c_OP_SLTU: w_alu[0] = (a < b);
            // Divide ops only reach this path as a zero-divisor or overflow case
            c_OP_DIV:  w_alu = w_div_zero ? '1 : a;
            c_OP_DIVU: w_alu = '1;
            c_OP_REM:  w_alu = w_div_zero ? a : '0;
            c_OP_REMU: w_alu = a;
            default:   w_alu = '0;
        endcase
    end

    assign w_acc_hi = acc_q[2*XLEN-1:XLEN];
    assign w_acc_lo = acc_q[XLEN-1:0];

    // Shift-add: multiplier sits in the low half and drains out as the product fills in
    assign w_mul_sum  = {1'b0, w_acc_hi} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign w_mul_next = {w_mul_sum, w_acc_lo[XLEN-1:1]};

    // Restoring step: partial remainder in the high half, quotient shifts into the low half
    assign w_div_shift = {w_acc_hi, w_acc_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, opd_q};
    assign w_div_next  = w_div_diff[XLEN] ?
                         {w_div_shift[XLEN-1:0], w_acc_lo[XLEN-2:0], 1'b0} :
                         {w_div_diff[XLEN-1:0],  w_acc_lo[XLEN-2:0], 1'b1};

    assign w_prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign w_quo     = neg_q ? (~w_acc_lo + 1'b1) : w_acc_lo;
    assign w_rem     = neg_q ? (~w_acc_hi + 1'b1) : w_acc_hi;
    assign w_fix_res = is_div_q ? (rem_q ? w_rem : w_quo) :
                       (hi_q ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            hi_q     <= 1'b0;
            rem_q    <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            state_q  <= S_CALC;
                            cnt_q    <= SHW'(XLEN-1);
                            is_div_q <= w_is_div;
                            hi_q     <= (op != c_OP_MUL);
                            rem_q    <= (op == c_OP_REM) || (op == c_OP_REMU);
                            neg_q    <= (op == c_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
                            if (w_is_div) begin
                                acc_q <= {{XLEN{1'b0}}, w_abs_a};
                                opd_q <= w_abs_b;
                            end else begin
                                acc_q <= {{XLEN{1'b0}}, w_abs_b};
                                opd_q <= w_abs_a;
                            end
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= w_alu;
                            zero_q   <= (w_alu == '0);
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q <= is_div_q ? w_div_next : w_mul_next;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    state_q  <= S_DONE;
                    result_q <= w_fix_res;
                    zero_q   <= (w_fix_res == '0);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
